// File: rtl/spi_rx.sv
// spi_rx: oversampling receiver for the two-wire SPI link (no chip-select).
// Recovers DATA_WIDTH-bit frames MSB first and hands them out on valid/ready.
//
// Ports:
//   i_clock        system clock, all logic on its rising edge
//   i_reset        synchronous, active-high reset
//   i_spi_clock    serial clock (asynchronous, idles low)
//   i_spi_data     serial data, valid at each i_spi_clock rise (asynchronous)
//   i_rx_ready     downstream accepts o_rx_data when o_rx_valid is also 1
//   o_rx_data      last received frame, held while o_rx_valid=1
//   o_rx_valid     holding register contains an unconsumed frame
//   o_busy         a frame is in progress
//   o_overrun      1-cycle pulse: completed frame overwrote an unconsumed one
//   o_frame_error  1-cycle pulse: frame aborted by inactivity timeout
module spi_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_spi_clock,
  input  logic                  i_spi_data,
  input  logic                  i_rx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_frame_error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam bit            ONE_BIT  = (DATA_WIDTH == 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic                  r_sclk_s1;
  logic                  r_sclk_s2;
  logic                  r_sclk_prev;
  logic                  r_sdat_s1;
  logic                  r_sdat_s2;
  logic                  r_edge;
  logic                  r_bit;
  logic [0:0]            r_state;
  logic [CW-1:0]         r_bit_cnt;
  logic [TW-1:0]         r_to_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_overrun;
  logic                  r_frame_error;

  logic                  w_rise;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // Edge and data are registered once more after detection so that the
  // shift happens three clocks after the rise is first sampled.
  assign w_rise = r_sclk_s2 & ~r_sclk_prev;

  always_comb begin
    w_shift_next    = r_shift << 1;
    w_shift_next[0] = r_bit;
    w_done = 1'b0;
    if (r_edge) begin
      if (r_state == S_IDLE)
        w_done = ONE_BIT;
      else
        w_done = (r_bit_cnt == LAST_BIT);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_sdat_s1   <= 1'b0;
      r_sdat_s2   <= 1'b0;
      r_edge      <= 1'b0;
      r_bit       <= 1'b0;
    end else begin
      r_sclk_s1   <= i_spi_clock;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_sdat_s1   <= i_spi_data;
      r_sdat_s2   <= r_sdat_s1;
      r_edge      <= w_rise;
      r_bit       <= r_sdat_s2;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_to_cnt      <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;

      if (r_rx_valid && i_rx_ready)
        r_rx_valid <= 1'b0;

      // A consume in the completion cycle frees the slot, so no overrun.
      if (w_done) begin
        r_rx_data  <= w_shift_next;
        r_rx_valid <= 1'b1;
        r_overrun  <= r_rx_valid && !i_rx_ready;
      end

      unique case (r_state)
        S_IDLE: begin
          r_to_cnt  <= '0;
          r_bit_cnt <= '0;
          if (r_edge && !ONE_BIT) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= CW'(1);
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_edge) begin
            r_to_cnt <= '0;
            if (w_done) begin
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_frame_error <= 1'b1;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_to_cnt      <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_busy        = (r_state == S_SHIFT);
  assign o_overrun     = r_overrun;
  assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: randomized bench for spi_rx against a cycle-indexed
// event model (completions, timeouts, busy window, handshake).
module tb_spi_rx;

  localparam int DW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          sdat = 1'b0;
  logic          rdy = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          overrun;
  logic          frame_error;

  spi_rx #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_spi_clock  (sclk),
    .i_spi_data   (sdat),
    .i_rx_ready   (rdy),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // Expected events, keyed by the clock edge at which they take effect.
  logic [7:0] comp [int];
  bit         fe   [int];
  int         busy_s = 0;
  int         busy_e = 0;

  int rmode = 0;
  bit rfix = 1'b0;
  int pulse_c = -1;

  bit         mvalid = 1'b0;
  logic [7:0] mdata = '0;
  bit         eov, efe, ebusy;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    #1;
    eov = 1'b0;
    efe = 1'b0;
    if (rst) begin
      mvalid = 1'b0;
      mdata  = '0;
    end else begin
      efe = fe.exists(cyc) ? 1'b1 : 1'b0;
      if (comp.exists(cyc)) begin
        eov    = mvalid && !rdy;
        mdata  = comp[cyc];
        mvalid = 1'b1;
      end else if (mvalid && rdy) begin
        mvalid = 1'b0;
      end
    end
    ebusy = !rst && cyc >= busy_s && cyc < busy_e;
    check("rx_valid", {31'd0, rx_valid}, {31'd0, mvalid});
    check("rx_data", {24'd0, rx_data}, {24'd0, mdata});
    check("busy", {31'd0, busy}, {31'd0, ebusy});
    check("overrun", {31'd0, overrun}, {31'd0, eov});
    check("frame_error", {31'd0, frame_error}, {31'd0, efe});
  end

  always @(negedge clk) begin
    case (rmode)
      0:       rdy = rfix;
      1:       rdy = 1'($urandom_range(0, 1));
      default: rdy = (cyc + 1 == pulse_c);
    endcase
  end

  // A rise driven just before edge k is shifted at edge k+3.
  task automatic send_frame(input logic [7:0] b, input int nbits,
                            input int half, input bit pulse,
                            output int last_s);
    int s;
    last_s = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      sdat = b[7-i];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      s = cyc + 1 + 3;
      if (i == 0) begin
        busy_s = s;
        busy_e = 32'h7fff_ffff;
      end
      if (i == nbits - 1) begin
        last_s = s;
        if (nbits == 8) begin
          comp[s] = b;
          busy_e  = s;
          if (pulse) pulse_c = s;
        end
      end
      repeat (half - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sclk = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic abort_frame(input logic [7:0] b, input int nbits,
                             input int half);
    int ls;
    send_frame(b, nbits, half, 1'b0, ls);
    fe[ls + TO] = 1'b1;
    busy_e = ls + TO;
    idle(TO + 10);
  endtask

  initial begin
    int ls;
    int half;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    rmode = 0; rfix = 1'b1;
    send_frame(8'hC6, 8, 4, 1'b0, ls);
    idle(8);

    rfix = 1'b0;
    send_frame(8'hA5, 8, 3, 1'b0, ls);
    idle(6);
    send_frame(8'h3C, 8, 3, 1'b0, ls);
    idle(6);
    pulse_c = cyc + 2;
    rmode = 2;
    idle(4);
    rmode = 0; rfix = 1'b0;

    send_frame(8'h11, 8, 2, 1'b0, ls);
    idle(6);
    rmode = 2;
    send_frame(8'h22, 8, 4, 1'b1, ls);
    idle(6);
    rmode = 0; rfix = 1'b1;
    idle(3);

    abort_frame(8'hE0, 3, 3);
    send_frame(8'h81, 8, 3, 1'b0, ls);
    idle(6);

    send_frame(8'hFF, 5, 3, 1'b0, ls);
    @(negedge clk);
    busy_e = cyc + 1;
    sclk = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_frame(8'h0F, 8, 3, 1'b0, ls);
    idle(6);

    send_frame(8'h00, 8, 2, 1'b0, ls);
    send_frame(8'hFF, 8, 2, 1'b0, ls);
    send_frame(8'h5A, 8, 2, 1'b0, ls);
    idle(8);

    for (int n = 0; n < 40; n++) begin
      rmode = int'($urandom_range(0, 1));
      rfix  = 1'($urandom_range(0, 1));
      half  = int'($urandom_range(2, 5));
      if ($urandom_range(0, 4) == 0)
        abort_frame(8'($urandom), int'($urandom_range(1, 7)), half);
      else
        send_frame(8'($urandom), 8, half, 1'b0, ls);
      if ($urandom_range(0, 2) == 0)
        idle(int'($urandom_range(1, 4)));
    end

    rmode = 0; rfix = 1'b1;
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
# spi_rx

Serial receiver for the team's two-wire SPI link (`spi_clock`, `spi_data`, no chip-select). It is the receiving end of the `spi` transmitter. It oversamples the link with the system clock, recovers each byte MSB first, and presents the byte on a valid/ready interface to downstream logic. It also flags aborted frames and unconsumed-byte overruns.

## Interface
- `DATA_WIDTH`, 8: bits per frame; also the width of `rx_data`.
- `TIMEOUT`, 64: system clocks with no `spi_clock` rising edge, mid-frame, before the frame is aborted. Legal range ≥ 4.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spi_clock`  in  1  serial clock from the transmitter; idles low; treated as asynchronous.
- `spi_data`  in  1  serial data; valid at each `spi_clock` rising edge; treated as asynchronous.
- `rx_data`  out  DATA_WIDTH  last received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  holding register contains an unconsumed byte.
- `rx_ready`  in  1  downstream accepts `rx_data` when `rx_valid` and `rx_ready` are both 1.
- `busy`  out  1  a frame is in progress (1 ≤ bits received < DATA_WIDTH).
- `overrun`  out  1  one-cycle pulse: a completed byte overwrote an unconsumed one.
- `frame_error`  out  1  one-cycle pulse: the frame was aborted by timeout.

## Operation
- **Input synchronisation**: `spi_clock` and `spi_data` each pass through a 2-flop synchroniser. A third register, `sclk_prev`, holds the previous synchronised `spi_clock`. A rising edge is detected when sync_sclk=1 and `sclk_prev`=0. Data is taken from the synchronised `spi_data`, aligned to the same stage.
- **State machine, IDLE**:
  - bit_cnt=0 and the timeout counter is held at 0.
  - On a detected edge: shift in the bit, bit_cnt=1, go to SHIFT.
  - If DATA_WIDTH=1, complete the frame immediately instead.
- **State machine, SHIFT**:
  - On each detected edge: shift_reg = {shift_reg[DATA_WIDTH-2:0], bit} (MSB first), increment bit_cnt, clear the timeout counter.
  - When the DATA_WIDTH-th bit is shifted in: complete the frame and return to IDLE.
  - With no edge: increment the timeout counter. When it reaches TIMEOUT: pulse `frame_error`, discard the partial byte, return to IDLE.
- **Frame completion**: load the assembled byte into `rx_data` and set `rx_valid`=1.
- **Handshake**:
  - `rx_valid` clears on the cycle after `rx_valid`&`rx_ready`.
  - `rx_data` does not change while `rx_valid`=1, except on overrun.
- **Simultaneous events**:
  - Completion while `rx_valid`=1 and `rx_ready`=0: the new byte overwrites `rx_data`, `rx_valid` stays 1, `overrun` pulses.
  - Completion while `rx_valid`=1 and `rx_ready`=1: the old byte is consumed and the new byte is loaded. `rx_valid` stays 1 and there is no overrun.
- `busy` = (state==SHIFT).
- **Reset**:
  - Reset at any time, including mid-frame, returns the block to IDLE.
  - All outputs are 0 and the shift register, bit_cnt, timeout counter and synchronisers are cleared. A partial frame is lost and no `frame_error` is raised.
  - The first edge after reset starts a new frame.

## Timing
- **Reset values**: `rx_data`=0, `rx_valid`=0, `busy`=0, `overrun`=0, `frame_error`=0.
- **Input constraint**: `spi_clock` high and low phases are each ≥ 2 system clocks, and `spi_data` is stable from 1 clock before to 2 clocks after each `spi_clock` rising edge.
  - The `spi` transmitter's divided clock meets this.
  - Faster inputs are unsupported; edges may be missed.
- **Edge latency**: a `spi_clock` rise first sampled at clock edge k is detected during cycle k+2 and shifted at edge k+3.
- **Byte latency**: `rx_valid` rises at edge k+3 of the final bit (3 clocks after the sampling edge).
- **Pulse outputs**: `overrun` and `frame_error` assert for exactly one cycle, coincident with the register update that causes them.
- **Timeout boundary**: `frame_error` asserts exactly TIMEOUT clocks after the last detected edge.
  - An edge detected in the same cycle the counter would reach TIMEOUT wins: the bit is shifted and there is no error.
- **Throughput**: back-to-back frames need no idle gap. The next frame's first edge may immediately follow the last edge of the previous frame.

## Test plan
- **Basic byte**: reset for 2 clocks, then send 8'b11000110 MSB first with a spi_clock half-period of 4 clocks, `rx_ready`=1.
  - `rx_data`=8'hC6 and `rx_valid` high for 1 cycle, 3 clocks after the 8th edge is sampled.
  - `busy` high from the 1st edge to the 8th; no `overrun` or `frame_error`.
- **Holding and overrun**: with `rx_ready`=0, send 8'hA5 then 8'h3C.
  - `rx_valid` stays 1 and `rx_data`=8'hA5 until the second frame completes.
  - Then `rx_data`=8'h3C and `overrun` pulses once.
  - Raising `rx_ready` for 1 cycle clears `rx_valid`.
- **Simultaneous completion and consume**: hold `rx_valid`=1 with 8'h11, assert `rx_ready` in exactly the completion cycle of 8'h22.
  - `rx_data`=8'h22, `rx_valid`=1, `overrun`=0.
- **Timeout abort**: send 3 bits, then stop `spi_clock` low.
  - `frame_error` pulses exactly TIMEOUT clocks after the 3rd edge; `busy`→0; `rx_valid` unchanged.
  - A following full 8'h81 frame is received correctly.
- **Reset mid-frame**: assert `reset` after 5 bits of 8'hFF.
  - All outputs are 0 and there is no `frame_error`.
  - After release, 8'h0F is received as 8'h0F.
- **Back-to-back**: send 8'h00, 8'hFF, 8'h5A with no gap and `rx_ready`=1.
  - Three `rx_valid` pulses with the values in order; no errors.
